// File: rtl/rob_cpl_pkg.sv
// Shared types for the ROB completion arbiter: source ids, completion entry layout
// and the round-robin successor used by the grant scan.
package rob_cpl_pkg;

  localparam int unsigned NUM_CPL_SRC    = 3;
  localparam int unsigned CPL_ROB_SIZE   = 10;
  localparam int unsigned CPL_IDX_W      = 4;
  localparam int unsigned CPL_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_MUL = 2'd2
  } cpl_src_t;

  typedef struct packed {
    logic [CPL_IDX_W-1:0] idx;
    logic [31:0]          value;
    logic [2:0]           exception;
  } cpl_entry_t;

  // Round-robin order ALU -> MEM -> MUL -> ALU
  function automatic cpl_src_t src_next(input cpl_src_t s);
    case (s)
      SRC_ALU: return SRC_MEM;
      SRC_MEM: return SRC_MUL;
      default: return SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/rob_complete_arbiter_if.sv
// Producer-side and ROB-side signals of the completion arbiter.
// master = producers/ROB environment, slave = the arbiter.
interface rob_complete_arbiter_if #(
  parameter int unsigned IDX_W = rob_cpl_pkg::CPL_IDX_W
);
  logic             in_alu_valid;
  logic [IDX_W-1:0] in_alu_idx;
  logic [31:0]      in_alu_value;
  logic [2:0]       in_alu_exception;
  logic             out_alu_ready;

  logic             in_mem_valid;
  logic [IDX_W-1:0] in_mem_idx;
  logic [31:0]      in_mem_value;
  logic [2:0]       in_mem_exception;
  logic             out_mem_ready;

  logic             in_mul_valid;
  logic [IDX_W-1:0] in_mul_idx;
  logic [31:0]      in_mul_value;
  logic [2:0]       in_mul_exception;
  logic             out_mul_ready;

  logic             in_rob_nuke;
  logic             out_complete;
  logic [IDX_W-1:0] out_complete_idx;
  logic [31:0]      out_complete_value;
  logic [2:0]       out_exception_vector;
  logic             out_busy;
  logic             out_idx_error;

  modport master (
    output in_alu_valid, in_alu_idx, in_alu_value, in_alu_exception,
    output in_mem_valid, in_mem_idx, in_mem_value, in_mem_exception,
    output in_mul_valid, in_mul_idx, in_mul_value, in_mul_exception,
    output in_rob_nuke,
    input  out_alu_ready, out_mem_ready, out_mul_ready,
    input  out_complete, out_complete_idx, out_complete_value,
    input  out_exception_vector, out_busy, out_idx_error
  );

  modport slave (
    input  in_alu_valid, in_alu_idx, in_alu_value, in_alu_exception,
    input  in_mem_valid, in_mem_idx, in_mem_value, in_mem_exception,
    input  in_mul_valid, in_mul_idx, in_mul_value, in_mul_exception,
    input  in_rob_nuke,
    output out_alu_ready, out_mem_ready, out_mul_ready,
    output out_complete, out_complete_idx, out_complete_value,
    output out_exception_vector, out_busy, out_idx_error
  );
endinterface

// File: rtl/rob_cpl_fifo.sv
// Per-source completion FIFO: registered count, modulo pointers, flush has priority
// over push/pop. Storage carries no reset; only pointers and count do.
module rob_cpl_fifo
  import rob_cpl_pkg::*;
#(
  parameter int unsigned DEPTH = CPL_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  cpl_entry_t i_data,
  output cpl_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  cpl_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rob_complete_arbiter.sv
// Merges ALU, load and multiplier completions onto one registered ROB completion
// bus via per-source FIFOs and a round-robin grant; a ROB nuke flushes everything.
module rob_complete_arbiter
  import rob_cpl_pkg::*;
#(
  parameter int unsigned ROB_SIZE   = CPL_ROB_SIZE,
  parameter int unsigned IDX_W      = CPL_IDX_W,
  parameter int unsigned FIFO_DEPTH = CPL_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  rob_complete_arbiter_if.slave bus
);

  logic [NUM_CPL_SRC-1:0] w_valid;
  logic [NUM_CPL_SRC-1:0] w_ready;
  logic [NUM_CPL_SRC-1:0] w_take;
  logic [NUM_CPL_SRC-1:0] w_legal;
  logic [NUM_CPL_SRC-1:0] w_push;
  logic [NUM_CPL_SRC-1:0] w_bad;
  logic [NUM_CPL_SRC-1:0] w_full;
  logic [NUM_CPL_SRC-1:0] w_empty;
  logic [NUM_CPL_SRC-1:0] w_grant;
  logic [IDX_W-1:0]       w_idx  [NUM_CPL_SRC];
  cpl_entry_t             w_in   [NUM_CPL_SRC];
  cpl_entry_t             w_head [NUM_CPL_SRC];
  cpl_src_t               w_gnt_src;
  cpl_entry_t             w_gnt_entry;

  logic       r_live;
  cpl_src_t   r_rr_ptr;
  logic       r_complete;
  cpl_entry_t r_cpl;
  logic       r_idx_error;

  assign w_valid  = {bus.in_mul_valid, bus.in_mem_valid, bus.in_alu_valid};
  assign w_idx[0] = bus.in_alu_idx;
  assign w_idx[1] = bus.in_mem_idx;
  assign w_idx[2] = bus.in_mul_idx;
  assign w_in[0]  = '{idx: w_idx[0], value: bus.in_alu_value, exception: bus.in_alu_exception};
  assign w_in[1]  = '{idx: w_idx[1], value: bus.in_mem_value, exception: bus.in_mem_exception};
  assign w_in[2]  = '{idx: w_idx[2], value: bus.in_mul_value, exception: bus.in_mul_exception};

  // Ready is held low until the first edge after reset so every output reads 0 in reset
  always_comb begin
    for (int unsigned i = 0; i < NUM_CPL_SRC; i++) begin
      w_ready[i] = r_live && !w_full[i];
      w_take[i]  = w_valid[i] && w_ready[i] && !bus.in_rob_nuke;
      w_legal[i] = (32'(w_idx[i]) < ROB_SIZE);
      w_push[i]  = w_take[i] && w_legal[i];
      w_bad[i]   = w_take[i] && !w_legal[i];
    end
  end

  for (genvar g = 0; g < int'(NUM_CPL_SRC); g++) begin : g_src
    rob_cpl_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_flush (bus.in_rob_nuke),
      .i_push  (w_push[g]),
      .i_pop   (w_grant[g]),
      .i_data  (w_in[g]),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // Scan starts at the source after the last grant and takes the first non-empty one
  always_comb begin
    cpl_src_t scan;
    logic     found;
    w_grant   = '0;
    w_gnt_src = r_rr_ptr;
    scan      = r_rr_ptr;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_CPL_SRC; k++) begin
      scan = src_next(scan);
      if (!found && !w_empty[scan]) begin
        w_grant[scan] = 1'b1;
        w_gnt_src     = scan;
        found         = 1'b1;
      end
    end
  end

  assign w_gnt_entry = w_head[w_gnt_src];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live      <= 1'b0;
      r_rr_ptr    <= SRC_MUL;
      r_complete  <= 1'b0;
      r_cpl       <= '0;
      r_idx_error <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_idx_error <= r_idx_error | (|w_bad);
      if (bus.in_rob_nuke) begin
        r_complete <= 1'b0;
      end else begin
        r_complete <= |w_grant;
        if (|w_grant) begin
          r_cpl    <= w_gnt_entry;
          r_rr_ptr <= w_gnt_src;
        end
      end
    end
  end

  assign bus.out_alu_ready        = w_ready[0];
  assign bus.out_mem_ready        = w_ready[1];
  assign bus.out_mul_ready        = w_ready[2];
  assign bus.out_complete         = r_complete;
  assign bus.out_complete_idx     = r_cpl.idx;
  assign bus.out_complete_value   = r_cpl.value;
  assign bus.out_exception_vector = r_cpl.exception;
  assign bus.out_busy             = (|(~w_empty)) | r_complete;
  assign bus.out_idx_error        = r_idx_error;

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Directed self-checking bench for rob_complete_arbiter with hand-computed
// completion order, backpressure, illegal-idx, nuke and async-reset cases.
module tb_rob_complete_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rob_complete_arbiter_if #(.IDX_W(4)) bus ();

  rob_complete_arbiter #(
    .ROB_SIZE   (10),
    .IDX_W      (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int src, input int unsigned idx, input logic [31:0] val,
                       input logic [2:0] exc);
    case (src)
      0: begin
        bus.in_alu_valid = 1'b1; bus.in_alu_idx = 4'(idx);
        bus.in_alu_value = val;  bus.in_alu_exception = exc;
      end
      1: begin
        bus.in_mem_valid = 1'b1; bus.in_mem_idx = 4'(idx);
        bus.in_mem_value = val;  bus.in_mem_exception = exc;
      end
      default: begin
        bus.in_mul_valid = 1'b1; bus.in_mul_idx = 4'(idx);
        bus.in_mul_value = val;  bus.in_mul_exception = exc;
      end
    endcase
  endtask

  task automatic idle();
    bus.in_alu_valid = 1'b0; bus.in_alu_idx = '0; bus.in_alu_value = '0; bus.in_alu_exception = '0;
    bus.in_mem_valid = 1'b0; bus.in_mem_idx = '0; bus.in_mem_value = '0; bus.in_mem_exception = '0;
    bus.in_mul_valid = 1'b0; bus.in_mul_idx = '0; bus.in_mul_value = '0; bus.in_mul_exception = '0;
    bus.in_rob_nuke  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic check_cpl(input string tag, input int unsigned idx, input logic [31:0] val);
    check({tag, "_vld"}, 64'(bus.out_complete), 64'd1);
    check({tag, "_idx"}, 64'(bus.out_complete_idx), 64'(idx));
    check({tag, "_val"}, 64'(bus.out_complete_value), 64'(val));
  endtask

  function automatic logic [2:0] readies();
    return {bus.out_alu_ready, bus.out_mem_ready, bus.out_mul_ready};
  endfunction

  initial begin
    int          exp_seq [11];
    int unsigned na;
    int unsigned nm;
    int unsigned nu;
    logic        acc_a;
    logic        acc_m;
    logic        acc_u;

    checks = 0;
    errors = 0;
    idle();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_complete", 64'(bus.out_complete), 64'd0);
    check("rst_busy", 64'(bus.out_busy), 64'd0);
    check("rst_ready", 64'(readies()), 64'd0);
    check("rst_idx_err", 64'(bus.out_idx_error), 64'd0);
    check("rst_idx", 64'(bus.out_complete_idx), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_ready", 64'(readies()), 64'b111);

    // 1: single ALU beat, two-edge latency, one-cycle pulse
    drive(0, 3, 32'hDEAD, 3'd0);
    tick();
    idle();
    check("t1_n_complete", 64'(bus.out_complete), 64'd0);
    check("t1_n_busy", 64'(bus.out_busy), 64'd1);
    tick();
    check_cpl("t1_n1", 3, 32'hDEAD);
    check("t1_n1_exc", 64'(bus.out_exception_vector), 64'd0);
    tick();
    check("t1_n2_complete", 64'(bus.out_complete), 64'd0);
    check("t1_n2_idx_hold", 64'(bus.out_complete_idx), 64'd3);
    check("t1_n2_busy", 64'(bus.out_busy), 64'd0);

    // 2: all three at once from reset -> ALU, MEM, MUL
    do_reset();
    drive(0, 1, 32'h11, 3'd0);
    drive(1, 2, 32'h22, 3'b101);
    drive(2, 4, 32'h44, 3'b010);
    tick();
    idle();
    tick();
    check_cpl("t2_c1", 1, 32'h11);
    tick();
    check_cpl("t2_c2", 2, 32'h22);
    check("t2_c2_exc", 64'(bus.out_exception_vector), 64'b101);
    tick();
    check_cpl("t2_c3", 4, 32'h44);
    check("t2_c3_exc", 64'(bus.out_exception_vector), 64'b010);
    tick();
    check("t2_done", 64'(bus.out_complete), 64'd0);

    // 3: contention with held valids; MUL fills and ready drops, nothing lost
    exp_seq = '{0, 1, 3, 5, 2, 4, 6, 7, 8, 9, 0};
    na = 0; nm = 0; nu = 0;
    for (int e = 1; e <= 11; e++) begin
      idle();
      if (na < 2) drive(0, 1 + na, 32'h300 + 32'(1 + na), 3'd0);
      if (nm < 2) drive(1, 3 + nm, 32'h300 + 32'(3 + nm), 3'd0);
      if (nu < 5) drive(2, 5 + nu, 32'h300 + 32'(5 + nu), 3'd0);
      acc_a = bus.in_alu_valid && bus.out_alu_ready;
      acc_m = bus.in_mem_valid && bus.out_mem_ready;
      acc_u = bus.in_mul_valid && bus.out_mul_ready;
      tick();
      if (acc_a) na++;
      if (acc_m) nm++;
      if (acc_u) nu++;
      if (exp_seq[e-1] == 0) begin
        check($sformatf("t3_e%0d_none", e), 64'(bus.out_complete), 64'd0);
      end else begin
        check_cpl($sformatf("t3_e%0d", e), exp_seq[e-1], 32'h300 + 32'(exp_seq[e-1]));
      end
      if (e == 2) check("t3_mul_ready_drop", 64'(bus.out_mul_ready), 64'd0);
    end
    idle();
    check("t3_mul_accepted", 64'(nu), 64'd5);
    check("t3_alu_accepted", 64'(na), 64'd2);

    // 4: illegal idx consumed, sticky error, next legal beat completes
    drive(1, 12, 32'hBAD, 3'd0);
    tick();
    idle();
    check("t4_no_cpl", 64'(bus.out_complete), 64'd0);
    check("t4_err_set", 64'(bus.out_idx_error), 64'd1);
    check("t4_busy", 64'(bus.out_busy), 64'd0);
    tick();
    check("t4_no_cpl2", 64'(bus.out_complete), 64'd0);
    drive(1, 5, 32'h55, 3'd0);
    tick();
    idle();
    tick();
    check_cpl("t4_legal", 5, 32'h55);
    check("t4_err_sticky", 64'(bus.out_idx_error), 64'd1);

    // 5: fill, then nuke with beats on the inputs
    drive(0, 1, 32'hA1, 3'd0);
    drive(1, 2, 32'hB2, 3'd0);
    drive(2, 3, 32'hC3, 3'd0);
    tick();
    drive(0, 4, 32'hA4, 3'd0);
    drive(1, 6, 32'hB6, 3'd0);
    drive(2, 7, 32'hC7, 3'd0);
    tick();
    check_cpl("t5_pre", 3, 32'hC3);
    check("t5_full_ready", 64'(readies()), 64'b001);
    drive(0, 8, 32'hA8, 3'd0);
    drive(1, 9, 32'hB9, 3'd0);
    bus.in_rob_nuke = 1'b1;
    tick();
    idle();
    check("t5_nuke_cpl", 64'(bus.out_complete), 64'd0);
    check("t5_nuke_busy", 64'(bus.out_busy), 64'd0);
    check("t5_nuke_ready", 64'(readies()), 64'b111);
    check("t5_nuke_idx_hold", 64'(bus.out_complete_idx), 64'd3);
    tick();
    check("t5_after_cpl", 64'(bus.out_complete), 64'd0);
    check("t5_after_busy", 64'(bus.out_busy), 64'd0);

    // 6: async reset mid-operation, ALU wins first grant afterwards
    drive(0, 1, 32'h61, 3'd0);
    drive(1, 2, 32'h62, 3'd0);
    tick();
    idle();
    tick();
    check_cpl("t6_pre", 1, 32'h61);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_cpl", 64'(bus.out_complete), 64'd0);
    check("t6_rst_idx", 64'(bus.out_complete_idx), 64'd0);
    check("t6_rst_val", 64'(bus.out_complete_value), 64'd0);
    check("t6_rst_busy", 64'(bus.out_busy), 64'd0);
    check("t6_rst_err", 64'(bus.out_idx_error), 64'd0);
    check("t6_rst_ready", 64'(readies()), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_rel_ready", 64'(readies()), 64'b111);
    check("t6_rel_busy", 64'(bus.out_busy), 64'd0);
    drive(1, 6, 32'h76, 3'd0);
    drive(0, 7, 32'h77, 3'd0);
    tick();
    idle();
    tick();
    check_cpl("t6_first_alu", 7, 32'h77);
    tick();
    check_cpl("t6_second_mem", 6, 32'h76);
    tick();
    check("t6_done", 64'(bus.out_complete), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
